// File: rtl/pipelined_hybrid_adder.sv
// Pipelined add/subtract for the FP adder mantissa path.
// The operation is split into STAGES slices of WIDTH/STAGES bits. Each slice has its own
// register stage, and the carry moves forward one slice per cycle. The low CLA_BITS of
// slice 0 use lookahead; every other bit ripples.
// Operand bits that have not been added yet are stored in a narrower register at each
// stage, so no stage keeps bits it will not use later.
module pipelined_hybrid_adder #(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned CLA_BITS = 4,
    parameter int unsigned STAGES   = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Out_Valid,
    input  logic             Out_Ready
);

    localparam int unsigned SLICE = WIDTH / STAGES;

    logic [STAGES-1:0] v;      // per-stage occupancy
    logic [STAGES-1:0] adv;    // stage k hands its slot forward this edge
    logic [STAGES-1:0] free;   // stage k can take a slot this edge

    // Backpressure chain: a stage is free when it is empty or its content moves on
    always_comb begin
        adv  = '0;
        free = '0;
        adv[STAGES-1] = Out_Ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            free[k] = !v[k] || adv[k];
            if (k > 0) begin
                adv[k-1] = free[k];
            end
        end
    end

    assign In_Ready = free[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned REM = WIDTH - k * SLICE;   // operand bits still to add

        logic [REM-1:0]           op_a;
        logic [REM-1:0]           op_b;
        logic                     op_c;
        logic                     op_v;
        logic [SLICE-1:0]         p;
        logic [SLICE-1:0]         g;
        logic [SLICE-1:0]         slice_sum;
        logic [SLICE:0]           cy;
        logic [(k+1)*SLICE-1:0]   sum_nxt;
        logic [(k+1)*SLICE-1:0]   s_q;
        logic                     c_q;
        logic                     v_q;

        if (k == 0) begin : g_src
            assign op_a    = A;
            assign op_b    = Sub ? ~B : B;
            assign op_c    = Sub | Cin;
            assign op_v    = In_Valid;
            assign sum_nxt = slice_sum;
        end else begin : g_src
            assign op_a    = g_stage[k-1].g_fwd.a_q;
            assign op_b    = g_stage[k-1].g_fwd.b_q;
            assign op_c    = g_stage[k-1].c_q;
            assign op_v    = v[k-1];
            assign sum_nxt = {slice_sum, g_stage[k-1].s_q};
        end

        // Slice adder: flattened lookahead carries for the low CLA_BITS of slice 0, ripple elsewhere
        always_comb begin
            logic cla;
            logic term;
            cla  = 1'b0;
            term = 1'b0;
            p    = op_a[SLICE-1:0] ^ op_b[SLICE-1:0];
            g    = op_a[SLICE-1:0] & op_b[SLICE-1:0];
            cy   = '0;
            cy[0] = op_c;
            for (int unsigned i = 0; i < SLICE; i++) begin
                if (k == 0 && i < CLA_BITS) begin
                    cla = op_c;
                    for (int unsigned j = 0; j <= i; j++) begin
                        cla = cla & p[j];
                    end
                    for (int unsigned j = 0; j <= i; j++) begin
                        term = g[j];
                        for (int unsigned m = j + 1; m <= i; m++) begin
                            term = term & p[m];
                        end
                        cla = cla | term;
                    end
                    cy[i+1] = cla;
                end else begin
                    cy[i+1] = g[i] | (p[i] & cy[i]);
                end
            end
            slice_sum = p ^ cy[SLICE-1:0];
        end

        // Stage slot: take the upstream slot whenever this stage is free
        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (free[k]) begin
                v_q <= op_v;
                if (op_v) begin
                    s_q <= sum_nxt;
                    c_q <= cy[SLICE];
                end
            end
        end

        assign v[k] = v_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-SLICE-1:0] a_q;
            logic [REM-SLICE-1:0] b_q;

            // Pass the operand bits that have not been added yet along with the slot
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (free[k] && op_v) begin
                    a_q <= op_a[REM-1:SLICE];
                    b_q <= op_b[REM-1:SLICE];
                end
            end
        end else begin : g_last
            logic ov_q;

            // Signed overflow: operands have the same sign but the result sign differs
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    ov_q <= 1'b0;
                end else if (free[k] && op_v) begin
                    ov_q <= (op_a[REM-1] == op_b[REM-1]) && (slice_sum[SLICE-1] != op_a[REM-1]);
                end
            end

            assign Sum       = s_q;
            assign Cout      = c_q;
            assign Overflow  = ov_q;
            assign Out_Valid = v_q;
        end
    end

endmodule

// File: tb/tb_pipelined_hybrid_adder.sv
// Self-checking bench for pipelined_hybrid_adder with the default parameters (24 bits, 2 stages).
module tb_pipelined_hybrid_adder;

    localparam int unsigned W = 24;
    localparam int unsigned S = 2;

    logic         Clk;
    logic         Rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Sub;
    logic         In_Valid;
    logic         In_Ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Overflow;
    logic         Out_Valid;
    logic         Out_Ready;

    int checks   = 0;
    int failures = 0;

    pipelined_hybrid_adder #(.WIDTH(W), .CLA_BITS(4), .STAGES(S)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Overflow  (Overflow),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic on A + Beff + Cin_eff, overflow from the signed range
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] be;
        longint       ce;
        longint       ua;
        longint       ub;
        longint       r;
        longint       sa;
        longint       sb;
        longint       sr;
        logic         ov;
        be = sub ? ~b : b;
        ce = (sub || cin) ? 64'sd1 : 64'sd0;
        ua = longint'(a);
        ub = longint'(be);
        r  = ua + ub + ce;
        sa = a[W-1]  ? ua - 64'sd16777216 : ua;
        sb = be[W-1] ? ub - 64'sd16777216 : ub;
        sr = sa + sb + ce;
        ov = (sr > 64'sd8388607) || (sr < -64'sd8388608);
        return {r[W-1:0], r[W], ov};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             tbl[11];
        logic [W+1:0]     q[$];
        logic [W+1:0]     exp_w;
        logic [W+1:0]     held;
        logic             stall_prev;
        logic             in_f;
        logic             out_f;
        int               i_next;
        int               got;

        tbl[0]  = '{24'h00000F, 24'h000001, 1'b0, 1'b0, 24'h000010, 1'b0, 1'b0};
        tbl[1]  = '{24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0};
        tbl[2]  = '{24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0};
        tbl[3]  = '{24'h000005, 24'h000007, 1'b1, 1'b1, 24'hFFFFFE, 1'b0, 1'b0};
        tbl[4]  = '{24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1};
        tbl[5]  = '{24'h800000, 24'h000001, 1'b0, 1'b1, 24'h7FFFFF, 1'b1, 1'b1};
        tbl[6]  = '{24'h0007FF, 24'h000801, 1'b0, 1'b0, 24'h001000, 1'b0, 1'b0};
        tbl[7]  = '{24'h000000, 24'h000000, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b0};
        tbl[8]  = '{24'h800000, 24'h800000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1};
        tbl[9]  = '{24'h00000F, 24'h000001, 1'b1, 1'b0, 24'h000011, 1'b0, 1'b0};
        tbl[10] = '{24'h123456, 24'h111111, 1'b0, 1'b0, 24'h234567, 1'b0, 1'b0};

        Rst = 1'b1; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
        #3;
        check("rst_out_valid", 32'(Out_Valid), 32'(0));
        check("rst_in_ready",  32'(In_Ready),  32'(1));
        check("rst_sum",       32'(Sum),       32'(0));
        check("rst_cout",      32'(Cout),      32'(0));
        check("rst_overflow",  32'(Overflow),  32'(0));
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;

        // Directed vectors, one at a time with latency check
        for (int t = 0; t < 11; t++) begin
            @(posedge Clk);
            #1;
            A = tbl[t].a; B = tbl[t].b; Cin = tbl[t].cin; Sub = tbl[t].sub;
            In_Valid = 1'b1; Out_Ready = 1'b1;
            #3;
            check($sformatf("vec%0d_in_ready", t), 32'(In_Ready), 32'(1));
            @(posedge Clk);
            #1 In_Valid = 1'b0;
            check($sformatf("vec%0d_early", t), 32'(Out_Valid), 32'(0));
            repeat (S - 1) @(posedge Clk);
            #1;
            check($sformatf("vec%0d_valid", t), 32'(Out_Valid), 32'(1));
            check($sformatf("vec%0d_sum", t),   32'(Sum),       32'(tbl[t].s));
            check($sformatf("vec%0d_cout", t),  32'(Cout),      32'(tbl[t].co));
            check($sformatf("vec%0d_ovf", t),   32'(Overflow),  32'(tbl[t].ov));
        end

        // Backpressure: stream i+i for i=1..8 while the output is stalled for 5 cycles
        i_next = 1; got = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(posedge Clk);
            #1;
            In_Valid = (i_next <= 8); A = W'(i_next); B = W'(i_next); Cin = 1'b0; Sub = 1'b0;
            Out_Ready = (cyc >= 5);
            #3;
            if (cyc >= 2 && cyc <= 4) begin
                check("bp_full_ready", 32'(In_Ready),  32'(0));
                check("bp_hold_valid", 32'(Out_Valid), 32'(1));
                check("bp_hold_sum",   32'(Sum),       32'(2));
            end
            if (cyc == 5) check("bp_simul_ready", 32'(In_Ready), 32'(1));
            in_f  = In_Valid && In_Ready;
            out_f = Out_Valid && Out_Ready;
            if (out_f) begin
                check($sformatf("bp_out%0d", got), 32'(Sum), 32'(2 * (got + 1)));
                got++;
            end
            if (in_f) i_next++;
        end
        check("bp_count", 32'(got), 32'(8));
        @(posedge Clk);
        #1 In_Valid = 1'b0; Out_Ready = 1'b1;
        @(posedge Clk);

        // Reset mid-flight with two operations in the pipe
        #1 Out_Ready = 1'b0; In_Valid = 1'b1; A = 24'h000001; B = 24'h000001;
        @(posedge Clk);
        #1 A = 24'h000002; B = 24'h000002;
        @(posedge Clk);
        #1 In_Valid = 1'b0;
        #1 check("mid_valid_before", 32'(Out_Valid), 32'(1));
        Rst = 1'b1;
        #1;
        check("mid_rst_valid",    32'(Out_Valid), 32'(0));
        check("mid_rst_in_ready", 32'(In_Ready),  32'(1));
        check("mid_rst_sum",      32'(Sum),       32'(0));
        Rst = 1'b0;
        @(posedge Clk);
        #1 A = 24'h123456; B = 24'h111111; Cin = 1'b0; Sub = 1'b0; In_Valid = 1'b1; Out_Ready = 1'b1;
        @(posedge Clk);
        #1 In_Valid = 1'b0;
        @(posedge Clk);
        #1;
        check("post_rst_valid", 32'(Out_Valid), 32'(1));
        check("post_rst_sum",   32'(Sum),       32'(24'h234567));
        @(posedge Clk);
        #1 check("post_rst_empty", 32'(Out_Valid), 32'(0));

        // Random traffic with random backpressure against the reference model
        stall_prev = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge Clk);
            #1;
            In_Valid  = ($urandom_range(0, 9) < 7);
            A         = W'($urandom);
            B         = W'($urandom);
            Cin       = 1'($urandom_range(0, 1));
            Sub       = 1'($urandom_range(0, 1));
            Out_Ready = ($urandom_range(0, 9) < 7);
            #3;
            if (stall_prev) begin
                check("rnd_stall_valid", 32'(Out_Valid), 32'(1));
                check("rnd_stall_hold",  32'({Sum, Cout, Overflow}), 32'(held));
            end
            in_f  = In_Valid && In_Ready;
            out_f = Out_Valid && Out_Ready;
            if (out_f) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected_out", 32'(Out_Valid), 32'(0));
                end else begin
                    exp_w = q.pop_front();
                    check("rnd_result", 32'({Sum, Cout, Overflow}), 32'(exp_w));
                end
            end
            if (in_f) q.push_back(model(A, B, Cin, Sub));
            stall_prev = Out_Valid && !Out_Ready;
            held = {Sum, Cout, Overflow};
        end

        // Drain whatever is left
        @(posedge Clk);
        #1 In_Valid = 1'b0; Out_Ready = 1'b1;
        for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
            #3;
            if (Out_Valid) begin
                exp_w = q.pop_front();
                check("drain_result", 32'({Sum, Cout, Overflow}), 32'(exp_w));
            end
            @(posedge Clk);
            #1;
        end
        check("drain_empty", 32'(q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
